mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 20 ++
 rtl/beat_timer.sv | 36 +++
 rtl/mem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the CPU-to-backing-store memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StReady,
    StHold
  } state_e;

  localparam int unsigned TimeoutDefault   = 255;
  localparam logic [16:0] InstrBaseDefault = 17'h10000;

  // Instruction words are 32 bits wide, stored as two consecutive 16-bit words.
  function automatic logic [16:0] instr_addr(logic [16:0] base, logic [15:0] addr, logic hi);
    return base + {addr, 1'b0} + {16'b0, hi};
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Per-beat wait counter: flags expiry on the Timeout-th enabled cycle since the last clear.
module beat_timer #(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == CntLast);

endmodule

// File: rtl/mem_responder.sv
// Bridges single-cycle CPU read/write/fetch requests onto a req/ack backing store,
// splitting instruction fetches into two 16-bit beats.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TimeoutDefault,
  parameter logic [16:0] INSTR_BASE = InstrBaseDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic        ram_instr_access,
  input  logic        ram_read_done,
  input  logic [15:0] e_addr_bus,
  input  logic [15:0] e_data,
  output logic [15:0] e_mem_bus,
  output logic [31:0] e_sdram_instr,
  output logic        e_mem_busy,
  output logic        e_mem_cack,
  output logic        e_mem_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [16:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        instr_q, instr_d;
  logic        done_q, done_d;
  logic        cack_q, cack_d;
  logic [15:0] rdata_q, rdata_d;
  logic [31:0] instr_data_q, instr_data_d;
  logic        err_q, err_d;
  logic        beat;
  logic        expire;

  // done_q marks the post-ack cycle of the final beat: m_req is low, READY follows.
  assign beat  = (state_q == StBeat0) || (state_q == StBeat1);
  assign m_req = beat && !done_q;

  beat_timer #(
    .Timeout(TIMEOUT)
  ) u_beat_timer (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (state_d != state_q),
    .enable_i(m_req),
    .expire_o(expire)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    instr_d      = instr_q;
    done_d       = done_q;
    cack_d       = 1'b0;
    rdata_d      = rdata_q;
    instr_data_d = instr_data_q;
    err_d        = err_q;
    case (state_q)
      StIdle: begin
        if (ram_read || ram_write) begin
          addr_d  = e_addr_bus;
          wdata_d = e_data;
          we_d    = ram_write;
          instr_d = !ram_write && ram_instr_access;
          done_d  = 1'b0;
          cack_d  = 1'b1;
          state_d = StBeat0;
          if (ram_read && ram_write) begin
            err_d = 1'b1;
          end
        end
      end
      StBeat0: begin
        if (done_q) begin
          done_d  = 1'b0;
          state_d = StReady;
        end else if (m_ack) begin
          if (instr_q) begin
            instr_data_d[15:0] = m_rdata;
            state_d            = StBeat1;
          end else begin
            if (!we_q) begin
              rdata_d = m_rdata;
            end
            done_d = 1'b1;
          end
        end else if (expire) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          if (instr_q) begin
            instr_data_d = 32'hFFFF_FFFF;
          end else if (!we_q) begin
            rdata_d = 16'hFFFF;
          end
        end
      end
      StBeat1: begin
        if (done_q) begin
          done_d  = 1'b0;
          state_d = StReady;
        end else if (m_ack) begin
          instr_data_d[31:16] = m_rdata;
          done_d              = 1'b1;
        end else if (expire) begin
          instr_data_d[31:16] = 16'hFFFF;
          err_d               = 1'b1;
          done_d              = 1'b1;
        end
      end
      StReady: begin
        state_d = (we_q || ram_read_done) ? StIdle : StHold;
      end
      StHold: begin
        if (ram_read_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      instr_q      <= 1'b0;
      done_q       <= 1'b0;
      cack_q       <= 1'b0;
      rdata_q      <= '0;
      instr_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      instr_q      <= instr_d;
      done_q       <= done_d;
      cack_q       <= cack_d;
      rdata_q      <= rdata_d;
      instr_data_q <= instr_data_d;
      err_q        <= err_d;
    end
  end

  assign e_mem_busy    = (state_q != StIdle);
  assign e_mem_cack    = cack_q;
  assign e_mem_ready   = (state_q == StReady);
  assign e_mem_bus     = rdata_q;
  assign e_sdram_instr = instr_data_q;
  assign bus_err       = err_q;
  assign m_we          = m_req && we_q;
  assign m_wdata       = m_req ? wdata_q : 16'h0000;
  assign m_addr        = !m_req ? 17'h00000 :
                         instr_q ? instr_addr(INSTR_BASE, addr_q, state_q == StBeat1) :
                         {1'b0, addr_q};

endmodule
